// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC-style instruction fetch path.
package pic_pkg;

    localparam int PC_W        = 11;
    localparam int INSN_W      = 14;
    localparam int STACK_DEPTH = 8;
    localparam int SP_W        = $clog2(STACK_DEPTH);

    localparam logic [INSN_W-1:0] NOP_WORD = 14'h0000;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH, HALT} fetch_state_t;

endpackage

// File: rtl/pic_ret_stack.sv
// Hardware return stack: circular 8x11 register file with sticky over/underflow flags.
// PIC_STACK_TRAP_EN: refuse the push at ptr=7 / pop at ptr=0, flag it and raise trap_o.
module pic_ret_stack
    import pic_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  logic            pop_i,
    input  pc_t             push_data_i,
    output pc_t             top_o,
    output logic [SP_W-1:0] ptr_o,
    output logic            ovf_o,
    output logic            unf_o,
    output logic            trap_o
);

    pc_t             mem_q [STACK_DEPTH];
    logic [SP_W-1:0] ptr_q;
    logic            ovf_q, unf_q;

    assign top_o = mem_q[ptr_q - SP_W'(1)];
    assign ptr_o = ptr_q;
    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

`ifdef PIC_STACK_TRAP_EN
    assign trap_o = (push_i && ptr_q == SP_W'(STACK_DEPTH-1)) || (pop_i && ptr_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            if (ptr_q == SP_W'(STACK_DEPTH-1)) begin
                ovf_q <= 1'b1;
            end else begin
                mem_q[ptr_q] <= push_data_i;
                ptr_q        <= ptr_q + SP_W'(1);
            end
        end else if (pop_i) begin
            if (ptr_q == '0) unf_q <= 1'b1;
            else             ptr_q <= ptr_q - SP_W'(1);
        end
    end
`else
    // Occupancy tells "full" apart from "empty", since both show ptr=0.
    logic [SP_W:0] cnt_q;

    assign trap_o = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) mem_q[i] <= '0;
        end else if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
            ptr_q        <= ptr_q + SP_W'(1);
            if (cnt_q == (SP_W+1)'(STACK_DEPTH)) ovf_q <= 1'b1;
            else                                 cnt_q <= cnt_q + (SP_W+1)'(1);
        end else if (pop_i) begin
            ptr_q <= ptr_q - SP_W'(1);
            if (cnt_q == '0) unf_q <= 1'b1;
            else             cnt_q <= cnt_q - (SP_W+1)'(1);
        end
    end
`endif

endmodule

// File: rtl/pic_fetch_ctrl.sv
// Fetch sequencer: owns the PC, loads the IR from the ROM, handles redirects with one bubble.
// PIC_STACK_TRAP_EN (inside pic_ret_stack) turns stack over/underflow into a permanent HALT.
module pic_fetch_ctrl
    import pic_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [PC_W-1:0]   Rom_addr_out,
    input  logic [INSN_W-1:0] Rom_data_in,
    input  logic              stall,
    input  logic              branch_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic              skip_en,
    input  logic              sleep_en,
    input  logic              wake,
    input  logic [PC_W-1:0]   branch_addr,
    output logic [INSN_W-1:0] ir_out,
    output logic              ir_valid,
    output logic [PC_W-1:0]   pc_of_ir,
    output logic [2:0]        stack_ptr,
    output logic              stack_ovf,
    output logic              stack_unf
);

    fetch_state_t      state_q, state_d;
    pc_t               pc_q, pc_d, pcir_q, pcir_d, stk_top;
    logic [INSN_W-1:0] ir_q, ir_d;
    logic              vld_q, vld_d, trap_q, trap_d;
    logic              push, pop, redirect, stk_trap;

    pic_ret_stack u_stack (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (pc_q),
        .top_o       (stk_top),
        .ptr_o       (stack_ptr),
        .ovf_o       (stack_ovf),
        .unf_o       (stack_unf),
        .trap_o      (stk_trap)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        vld_d    = vld_q;
        pcir_d   = pcir_q;
        trap_d   = trap_q;
        push     = 1'b0;
        pop      = 1'b0;
        redirect = 1'b0;
        if (!stall) begin
            case (state_q)
                BOOT, FLUSH: begin
                    ir_d    = Rom_data_in;
                    vld_d   = 1'b1;
                    pcir_d  = pc_q;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = RUN;
                end
                RUN: begin
                    if (ret_en) begin
                        pop      = 1'b1;
                        pc_d     = stk_top;
                        redirect = 1'b1;
                    end else if (call_en) begin
                        push     = 1'b1;
                        pc_d     = branch_addr;
                        redirect = 1'b1;
                    end else if (branch_en) begin
                        pc_d     = branch_addr;
                        redirect = 1'b1;
                    end else if (skip_en) begin
                        pc_d     = pc_q + PC_W'(1);
                        redirect = 1'b1;
                    end else if (sleep_en) begin
                        ir_d    = NOP_WORD;
                        vld_d   = 1'b0;
                        state_d = HALT;
                    end else begin
                        ir_d   = Rom_data_in;
                        vld_d  = 1'b1;
                        pcir_d = pc_q;
                        pc_d   = pc_q + PC_W'(1);
                    end
                    if (redirect) begin
                        ir_d    = NOP_WORD;
                        vld_d   = 1'b0;
                        state_d = FLUSH;
                    end
                    // A refused push/pop freezes the PC and locks the core in HALT.
                    if (stk_trap) begin
                        pc_d    = pc_q;
                        ir_d    = NOP_WORD;
                        vld_d   = 1'b0;
                        trap_d  = 1'b1;
                        state_d = HALT;
                    end
                end
                HALT: begin
                    vld_d = 1'b0;
                    if (wake && !trap_q) state_d = RUN;
                end
                default: state_d = BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= '0;
            ir_q    <= NOP_WORD;
            vld_q   <= 1'b0;
            pcir_q  <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            vld_q   <= vld_d;
            pcir_q  <= pcir_d;
            trap_q  <= trap_d;
        end
    end

    assign Rom_addr_out = pc_q;
    assign ir_out       = ir_q;
    assign ir_valid     = vld_q;
    assign pc_of_ir     = pcir_q;

endmodule

// File: tb/tb_pic_fetch_ctrl.sv
// Directed bench for pic_fetch_ctrl (default build, circular stack).
module tb_pic_fetch_ctrl;
    import pic_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [PC_W-1:0]   Rom_addr_out;
    logic [INSN_W-1:0] Rom_data_in;
    logic              stall, branch_en, call_en, ret_en, skip_en, sleep_en, wake;
    logic [PC_W-1:0]   branch_addr;
    logic [INSN_W-1:0] ir_out;
    logic              ir_valid;
    logic [PC_W-1:0]   pc_of_ir;
    logic [2:0]        stack_ptr;
    logic              stack_ovf, stack_unf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // ROM contents: two fixed boot words, otherwise 3'b101 tagged onto the address.
    function automatic logic [INSN_W-1:0] rom(input logic [PC_W-1:0] a);
        if (a == 11'd0) return 14'h01A5;
        if (a == 11'd1) return 14'h0103;
        return {3'b101, a};
    endfunction

    assign Rom_data_in = rom(Rom_addr_out);

    pic_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Rom_addr_out (Rom_addr_out),
        .Rom_data_in  (Rom_data_in),
        .stall        (stall),
        .branch_en    (branch_en),
        .call_en      (call_en),
        .ret_en       (ret_en),
        .skip_en      (skip_en),
        .sleep_en     (sleep_en),
        .wake         (wake),
        .branch_addr  (branch_addr),
        .ir_out       (ir_out),
        .ir_valid     (ir_valid),
        .pc_of_ir     (pc_of_ir),
        .stack_ptr    (stack_ptr),
        .stack_ovf    (stack_ovf),
        .stack_unf    (stack_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; branch_en = 1'b0; call_en = 1'b0; ret_en = 1'b0;
        skip_en = 1'b0; sleep_en = 1'b0; wake = 1'b0; branch_addr = '0;
        #12;
        chk("rst_addr", Rom_addr_out, 0);
        chk("rst_ir", ir_out, 0);
        chk("rst_vld", ir_valid, 0);
        chk("rst_ptr", stack_ptr, 0);
        chk("rst_flags", {stack_ovf, stack_unf}, 0);
        rst_n = 1'b1;

        // boot sequence
        step(); chk("boot_ir", ir_out, 14'h01A5); chk("boot_vld", ir_valid, 1); chk("boot_pcir", pc_of_ir, 0);
        step(); chk("run1_ir", ir_out, 14'h0103); chk("run1_addr", Rom_addr_out, 2);
        step(); chk("run2_ir", ir_out, rom(11'd2)); chk("run2_addr", Rom_addr_out, 3);

        // GOTO 0x00A at PC=3
        branch_en = 1'b1; branch_addr = 11'h00A;
        step(); chk("br_vld", ir_valid, 0); chk("br_addr", Rom_addr_out, 11'h00A);
        branch_en = 1'b0;
        step(); chk("br_ir", ir_out, rom(11'h00A)); chk("br_pcir", pc_of_ir, 11'h00A); chk("br_vld2", ir_valid, 1);

        // get PC=5 in RUN, then CALL 0x100 and RETURN at 0x102
        branch_en = 1'b1; branch_addr = 11'h004;
        step(); branch_en = 1'b0;
        step(); chk("pre_call_addr", Rom_addr_out, 5);
        call_en = 1'b1; branch_addr = 11'h100;
        step(); chk("call_ptr", stack_ptr, 1); chk("call_addr", Rom_addr_out, 11'h100); chk("call_vld", ir_valid, 0);
        call_en = 1'b0;
        step(); chk("call_ir", ir_out, rom(11'h100));
        step(); chk("pre_ret_addr", Rom_addr_out, 11'h102);
        ret_en = 1'b1;
        step(); chk("ret_ptr", stack_ptr, 0); chk("ret_addr", Rom_addr_out, 5); chk("ret_vld", ir_valid, 0);
        ret_en = 1'b0;
        step(); chk("ret_ir", ir_out, rom(11'd5)); chk("ret_pcir", pc_of_ir, 5); chk("ret_vld2", ir_valid, 1);

        // nine consecutive calls: pointer wraps, 9th push overflows
        for (int i = 0; i < 9; i++) begin
            call_en = 1'b1; branch_addr = 11'(11'h200 + i * 16);
            step();
            chk("call9_ptr", stack_ptr, (i + 1) % 8);
            chk("call9_ovf", stack_ovf, (i == 8) ? 1 : 0);
            chk("call9_addr", Rom_addr_out, 11'h200 + i * 16);
            call_en = 1'b0;
            step();
        end
        ret_en = 1'b1;
        step(); chk("pop_wrap0_addr", Rom_addr_out, 11'h271); chk("pop_wrap0_ptr", stack_ptr, 0);
        ret_en = 1'b0;
        step();
        ret_en = 1'b1;
        step(); chk("pop_e7_addr", Rom_addr_out, 11'h261); chk("pop_e7_ptr", stack_ptr, 7); chk("pop_unf0", stack_unf, 0);
        ret_en = 1'b0;
        step();

        // skip at PC=7
        branch_en = 1'b1; branch_addr = 11'h006;
        step(); branch_en = 1'b0;
        step(); chk("pre_skip_addr", Rom_addr_out, 7);
        skip_en = 1'b1;
        step(); chk("skip_vld", ir_valid, 0); chk("skip_addr", Rom_addr_out, 8);
        skip_en = 1'b0;
        step(); chk("skip_ir", ir_out, rom(11'd8)); chk("skip_pcir", pc_of_ir, 8); chk("skip_vld2", ir_valid, 1);

        // stall holds everything, even with branch_en raised
        stall = 1'b1; branch_en = 1'b1; branch_addr = 11'h030;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", Rom_addr_out, 9);
            chk("stall_ir", ir_out, rom(11'd8));
            chk("stall_vld", ir_valid, 1);
            chk("stall_ptr", stack_ptr, 7);
        end
        stall = 1'b0;
        step(); chk("unstall_addr", Rom_addr_out, 11'h030); chk("unstall_vld", ir_valid, 0);
        branch_en = 1'b0;
        step(); chk("unstall_ir", ir_out, rom(11'h030));

        // sleep at PC=0x0C, stall blocks wake, then wake
        branch_en = 1'b1; branch_addr = 11'h00B;
        step(); branch_en = 1'b0;
        step(); chk("pre_sleep_addr", Rom_addr_out, 11'h00C);
        sleep_en = 1'b1;
        step(); chk("sleep_addr", Rom_addr_out, 11'h00C); chk("sleep_vld", ir_valid, 0);
        sleep_en = 1'b0;
        step(); chk("halt_addr", Rom_addr_out, 11'h00C);
        stall = 1'b1; wake = 1'b1;
        step(); stall = 1'b0; wake = 1'b0;
        step(); chk("stall_wake_addr", Rom_addr_out, 11'h00C); chk("stall_wake_vld", ir_valid, 0);
        wake = 1'b1;
        step(); chk("wake_addr", Rom_addr_out, 11'h00C); chk("wake_vld", ir_valid, 0);
        wake = 1'b0;
        step(); chk("wake_ir", ir_out, rom(11'h00C)); chk("wake_pcir", pc_of_ir, 11'h00C); chk("wake_vld2", ir_valid, 1);

        // PC wrap 0x7FF -> 0x000
        branch_en = 1'b1; branch_addr = 11'h7FE;
        step(); branch_en = 1'b0;
        step(); chk("pre_wrap_addr", Rom_addr_out, 11'h7FF);
        step(); chk("wrap_addr", Rom_addr_out, 0); chk("wrap_ir", ir_out, rom(11'h7FF));

        // asynchronous reset during FLUSH
        branch_en = 1'b1; branch_addr = 11'h050;
        step(); branch_en = 1'b0;
        chk("pre_arst_addr", Rom_addr_out, 11'h050);
        rst_n = 1'b0;
        #1;
        chk("arst_addr", Rom_addr_out, 0);
        chk("arst_ir", ir_out, 0);
        chk("arst_vld", ir_valid, 0);
        chk("arst_pcir", pc_of_ir, 0);
        chk("arst_ptr", stack_ptr, 0);
        chk("arst_ovf", stack_ovf, 0);
        #1;
        rst_n = 1'b1;
        step(); chk("reboot_ir", ir_out, 14'h01A5); chk("reboot_addr", Rom_addr_out, 1);

        // pop on empty stack: pointer wraps to 7, underflow latches
        ret_en = 1'b1;
        step(); chk("unf_addr", Rom_addr_out, 0); chk("unf_ptr", stack_ptr, 7); chk("unf_flag", stack_unf, 1);
        ret_en = 1'b0;
        step(); chk("unf_ir", ir_out, 14'h01A5); chk("unf_pcir", pc_of_ir, 0); chk("unf_ovf", stack_ovf, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
